// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry byte buffer, overrun flag and frame-error pulse.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote per bit, one cycle later.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       ren,
    output logic [7:0] dout,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = HALF + 1;
`else
    localparam int START_DEC = HALF;
`endif
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DEC);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_meta_p0;
    logic             rxs;
    logic             bit_val;

    function automatic logic vote(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchronizer stage: rx_in -> rx_meta_p0 -> rxs, idle-high after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rxs        <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_in;
            rxs        <= rx_meta_p0;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Vote window: the two previous rxs samples plus the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxs};
        end
    end

    always_comb begin
        bit_val = vote(hist[1], hist[0], rxs);
    end
`else
    always_comb begin
        bit_val = rxs;
    end
`endif

    // Frame FSM and registered output buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            dout      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ren && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == START_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= bit_val ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_val) begin
                            // A read in the same cycle consumes the old byte, so no overrun
                            dout    <= shreg;
                            valid   <= 1'b1;
                            overrun <= valid & ~ren;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, overrun, glitch, frame error, reset and bit-2 glitch.
module tb_uart_rx;

    localparam int C    = 256;
    localparam int HALF = C / 2;
    localparam int FULL = 10 * C;
`ifdef UART_RX_MAJORITY_EN
    localparam int         MAJ        = 1;
    localparam logic [7:0] GLITCH_EXP = 8'h41;
`else
    localparam int         MAJ        = 0;
    localparam logic [7:0] GLITCH_EXP = 8'h45;
`endif
    // Edges from start-bit fall to valid: 2 sync + 1 detect + C/2 + 9C + 1 output
    localparam int LAT = 2 + 1 + HALF + 9 * C + 1 + MAJ;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       ren = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       overrun;
    logic       frame_err;

    int   n_checks = 0;
    int   n_pass = 0;
    int   rise_at;
    int   fe_at;
    int   fe_cnt;
    logic prev_valid;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .ren      (ren),
        .dout     (dout),
        .valid    (valid),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe(input int i);
        if (!prev_valid && valid && rise_at < 0) rise_at = i;
        prev_valid = valid;
        if (frame_err) begin
            fe_cnt++;
            if (fe_at < 0) fe_at = i;
        end
    endtask

    task automatic clear_obs();
        rise_at    = -1;
        fe_at      = -1;
        fe_cnt     = 0;
        prev_valid = valid;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            observe(100000 + k);
        end
    endtask

    // Drives one cycle per negedge: index i lies in bit i/C (0 = start, 1..8 data, 9 stop)
    task automatic send(input logic [7:0] b, input logic stop_b, input int glitch_at,
                        input int ren_at, input int ncyc);
        int   idx;
        logic v;
        clear_obs();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            observe(i);
            idx = i / C;
            if (idx == 0) v = 1'b0;
            else if (idx <= 8) v = b[idx-1];
            else v = stop_b;
            if (i == glitch_at) v = ~v;
            rx_in = v;
            ren   = (i == ren_at);
        end
        @(negedge clk);
        observe(ncyc);
        ren = 1'b0;
    endtask

    task automatic pulse_ren();
        @(negedge clk);
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        idle(10);

        // Single clean frame and read
        send(8'h41, 1'b1, -1, -1, FULL);
        check("t1_latency", rise_at, LAT);
        check("t1_dout", dout, 8'h41);
        check("t1_valid", valid, 1'b1);
        check("t1_frame_err", fe_cnt, 0);
        check("t1_overrun", overrun, 1'b0);
        pulse_ren();
        check("t1_ren_clears", valid, 1'b0);
        pulse_ren();
        check("t1_ren_empty_valid", valid, 1'b0);
        check("t1_ren_empty_dout", dout, 8'h41);

        // Back-to-back frames without a read
        send(8'h41, 1'b1, -1, -1, FULL);
        send(8'h30, 1'b1, -1, -1, FULL);
        check("t2_dout", dout, 8'h30);
        check("t2_valid", valid, 1'b1);
        check("t2_overrun", overrun, 1'b1);
        pulse_ren();
        check("t2_ren_valid", valid, 1'b0);
        check("t2_ren_overrun", overrun, 1'b0);

        // Read lands on the completion cycle of the next byte
        send(8'h41, 1'b1, -1, -1, FULL);
        send(8'h30, 1'b1, -1, LAT - 1, FULL);
        check("t2b_dout", dout, 8'h30);
        check("t2b_valid", valid, 1'b1);
        check("t2b_overrun", overrun, 1'b0);
        send(8'h6B, 1'b1, -1, -1, FULL);
        check("t2b_next_dout", dout, 8'h6B);
        check("t2b_next_overrun", overrun, 1'b1);
        pulse_ren();

        // Short low pulse is rejected as a glitch
        clear_obs();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            observe(k);
            rx_in = 1'b0;
        end
        rx_in = 1'b1;
        idle(3 * C);
        check("t3_valid", valid, 1'b0);
        check("t3_frame_err", fe_cnt, 0);
        check("t3_dout", dout, 8'h6B);
        send(8'h55, 1'b1, -1, -1, FULL);
        check("t3_next_dout", dout, 8'h55);
        check("t3_next_valid", valid, 1'b1);
        pulse_ren();

        // Stop bit low, line held low for two bit times
        send(8'h41, 1'b0, -1, -1, FULL);
        idle(C);
        check("t4_fe_count", fe_cnt, 1);
        check("t4_fe_time", fe_at, LAT);
        check("t4_valid", valid, 1'b0);
        check("t4_dout", dout, 8'h55);
        rx_in = 1'b1;
        idle(C);
        send(8'h30, 1'b1, -1, -1, FULL);
        check("t4_next_dout", dout, 8'h30);
        check("t4_next_valid", valid, 1'b1);
        check("t4_next_fe", fe_cnt, 0);

        // Reset in the middle of data bit 4
        send(8'h41, 1'b1, -1, -1, 5 * C + HALF);
        @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("t5_rst_dout", dout, 8'h00);
        check("t5_rst_valid", valid, 1'b0);
        check("t5_rst_overrun", overrun, 1'b0);
        check("t5_rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        idle(10);
        send(8'h41, 1'b1, -1, -1, FULL);
        check("t5_dout", dout, 8'h41);
        check("t5_valid", valid, 1'b1);
        check("t5_overrun", overrun, 1'b0);
        check("t5_latency", rise_at, LAT);

        // One-cycle inversion at the bit-2 sample point
        pulse_ren();
        send(8'h41, 1'b1, HALF + 1 + 3 * C, -1, FULL);
        check("t6_glitch_dout", dout, GLITCH_EXP);
        check("t6_glitch_valid", valid, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the RPN calculator datapath: deserializes 8N1 frames from the host line into bytes and holds each byte in a one-entry buffer until the downstream consumer reads it. It sits at the input end of the design, mirroring `uart_tx` at the output. Received bytes flow to the RPN parser, and results return to the host through `uart_tx`.

## Interface
- `CLKS_PER_BIT`, default 1085: clock cycles per bit. 125 MHz / 115200 baud gives 8681 ns per bit.
- `clk` input 1: system clock, 125 MHz nominal.
- `rst` input 1: asynchronous, active-high reset.
- `rx_in` input 1: serial line. Idle high; asynchronous to `clk`.
- `ren` input 1: read enable. Acknowledges and clears the buffered byte.
- `dout` output 8: last received byte.
- `valid` output 1: `dout` holds an unread byte.
- `overrun` output 1: sticky. A byte was overwritten before it was read.
- `frame_err` output 1: one-cycle pulse. The stop bit was sampled low.

## Operation
- `rx_in` passes through a 2-FF synchronizer; both flops reset to 1. All logic uses the synchronized signal `rxs`.
- Bit counter is 3 bits; cycle counter is sized for `CLKS_PER_BIT-1`.
- State machine:
  - IDLE:
    - `rxs`=0 → START, cycle counter cleared.
  - START:
    - At count `CLKS_PER_BIT/2` (floor), sample the line.
    - Sample 0 → DATA, bit index 0.
    - Sample 1 → glitch; return to IDLE with no outputs.
  - DATA:
    - Sample every `CLKS_PER_BIT` cycles.
    - Shift in LSB first.
    - After bit 7 → STOP.
  - STOP:
    - Sample after `CLKS_PER_BIT`.
    - Sample 1 → load `dout`, set `valid`, go to IDLE.
    - Sample 0 → pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK:
    - Wait for `rxs`=1 → IDLE. This prevents a held-low line from being re-detected as start bits.
- Buffer rules:
  - `ren` with `valid`=1: clears `valid` and `overrun` on the next edge.
  - `ren` with `valid`=0: ignored.
  - New byte completes while `valid`=1 and no `ren`: `dout` is overwritten, `valid` stays 1, `overrun` is set.
  - New byte completes in the same cycle as `ren`: the new byte is loaded, `valid` stays 1, `overrun` is cleared (not set).
- A frame error never modifies `dout`, `valid` or `overrun`.

## Timing
- Reset values:
  - `dout`=0x00
  - `valid`=0, `overrun`=0, `frame_err`=0
  - State IDLE, counters 0.
- Reset mid-frame aborts the frame. No partial byte is ever exposed.
- Latency from the `rx_in` start-bit falling edge to `valid`=1:
  - 2 synchronizer cycles
  - plus 1 detect cycle
  - plus `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`
  - plus 1 output register cycle
  - ±1 cycle for edge phase.
- `frame_err` is high for exactly one cycle, in the same cycle `valid` would have been set.
- After a good stop sample the block is in IDLE immediately. A back-to-back start bit is accepted with no gap.
- All outputs are registered. There is no combinational path from `rx_in` or `ren` to any output.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each bit is decided by a 2-of-3 vote of samples at the nominal sample point −1, 0 and +1 cycle. The decision, and all downstream latencies, land 1 cycle later than without the macro. This applies to the START check too.
  - Undefined: a single sample at the nominal sample point; no extra latency.

## Test plan
- Clock period 8 ns, bit time 8681 ns. Send 0x41 ('A') 8N1 → `valid` rises about 9.5 bit times after the start edge, `dout`=0x41, `frame_err`=0. Then pulse `ren` for 1 cycle → `valid`=0 on the next edge.
- Send 0x41, then immediately 0x30 ('0') with no `ren` → after the second frame `dout`=0x30, `valid`=1, `overrun`=1. Then pulse `ren` → `valid`=0, `overrun`=0.
- Drive `rx_in` low for 100 cycles, then high → `valid`, `frame_err` and `dout` are unchanged, and the FSM returns to IDLE. A following 0x55 frame is received correctly.
- Send 0x41 with the stop bit driven 0, holding the line low for 2 bit times → one-cycle `frame_err` pulse, `valid` stays 0, `dout` unchanged. After the line returns high, 0x30 is received correctly.
- Assert `rst` during data bit 4 of a frame → all outputs return to reset values. The next full 0x41 frame is received correctly.
- With `UART_RX_MAJORITY_EN` defined: send 0x41 with a 1-cycle inverted glitch exactly at the bit-2 sample point → `dout`=0x41. Without the macro, the same stimulus yields `dout`=0x45.
